// File: rtl/crypto_wallet_pi_gpio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_wallet_pi_gpio_pkg : shared constants and types for the GPIO poller |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package crypto_wallet_pi_gpio_pkg;

    localparam logic [1:0] c_csr_ctrl   = 2'd0;
    localparam logic [1:0] c_csr_period = 2'd1;
    localparam logic [1:0] c_csr_status = 2'd2;
    localparam logic [1:0] c_csr_edge   = 2'd3;

    localparam int c_ctrl_en_bit     = 0;
    localparam int c_ctrl_irq_en_bit = 1;

    // Wide enough for the largest supported DEBOUNCE (15)
    localparam int c_db_cnt_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_READ    = 2'd2,
        ST_CAPTURE = 2'd3
    } poll_state_e;

    // A PERIOD of 0 behaves like 1, so the wait counter reloads with max(p,1)-1
    function automatic logic [15:0] period_reload(input logic [15:0] p);
        return (p == 16'd0) ? 16'd0 : p - 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_wallet_pi_gpio_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_wallet_pi_gpio_debounce : one-bit poll-count debouncer              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module crypto_wallet_pi_gpio_debounce #(
    parameter int DEBOUNCE = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic sample_en,
    input  logic sample,
    output logic stable,
    output logic edge_pulse
);
    import crypto_wallet_pi_gpio_pkg::*;

    localparam logic [c_db_cnt_w-1:0] c_last = c_db_cnt_w'(DEBOUNCE - 1);
    localparam logic [c_db_cnt_w-1:0] c_one  = c_db_cnt_w'(1);

    logic [c_db_cnt_w-1:0] cnt_q, cnt_d;
    logic                  stable_q, stable_d;

    always_comb begin
        cnt_d      = cnt_q;
        stable_d   = stable_q;
        edge_pulse = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (sample_en) begin
            if (sample == stable_q) begin
                cnt_d = '0;
            end else if (cnt_q == c_last) begin
                // This poll is the DEBOUNCE-th consecutive disagreement
                stable_d   = sample;
                cnt_d      = '0;
                edge_pulse = 1'b1;
            end else begin
                cnt_d = cnt_q + c_one;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule
`default_nettype wire

// File: rtl/crypto_wallet_pi_gpio_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | crypto_wallet_pi_gpio_poller : periodic PIO poller with debounce, edge IRQ |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module crypto_wallet_pi_gpio_poller #(
    parameter int          WIDTH        = 2,
    parameter logic [15:0] PERIOD_RESET = 16'd1000,
    parameter int          DEBOUNCE     = 3
) (
    input  logic        clk,
    input  logic        reset,
    output logic [1:0]  pio_address,
    output logic        pio_read,
    input  logic [31:0] pio_readdata,
    input  logic [1:0]  csr_address,
    input  logic        csr_read,
    input  logic        csr_write,
    input  logic [31:0] csr_writedata,
    output logic [31:0] csr_readdata,
    output logic        irq
);
    import crypto_wallet_pi_gpio_pkg::*;

    poll_state_e       state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic [15:0]       period_q, period_d;
    logic [WIDTH-1:0]  edge_q, edge_d;
    logic [31:0]       csr_readdata_q, csr_readdata_d;

    logic              w_en;
    logic              w_sample_en;
    logic              w_db_clr;
    logic [WIDTH-1:0]  w_status;
    logic [WIDTH-1:0]  w_edge_set;
    logic [WIDTH-1:0]  w_edge_clr;
    logic [31:0]       w_rdata;
    logic              w_unused_bits;

    assign w_en          = ctrl_q[c_ctrl_en_bit];
    assign w_db_clr      = ~w_en;
    assign w_unused_bits = ^{pio_readdata[31:WIDTH], csr_writedata[31:16]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        w_sample_en = 1'b0;
        if (!w_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_WAIT;
                    cnt_d   = period_reload(period_q);
                end
                ST_WAIT: begin
                    if (cnt_q == 16'd0) begin
                        state_d = ST_READ;
                    end else begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
                ST_READ: begin
                    state_d = ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    w_sample_en = 1'b1;
                    state_d     = ST_WAIT;
                    cnt_d       = period_reload(period_q);
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an asynchronous reset drops the strobe at once
    assign pio_read    = (state_q == ST_READ);
    assign pio_address = 2'b00;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        crypto_wallet_pi_gpio_debounce #(
            .DEBOUNCE (DEBOUNCE)
        ) u_debounce (
            .clk        (clk),
            .reset      (reset),
            .clr        (w_db_clr),
            .sample_en  (w_sample_en),
            .sample     (pio_readdata[g]),
            .stable     (w_status[g]),
            .edge_pulse (w_edge_set[g])
        );
    end

    always_comb begin
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        w_edge_clr = '0;
        if (csr_write) begin
            case (csr_address)
                c_csr_ctrl:   ctrl_d     = csr_writedata[1:0];
                c_csr_period: period_d   = csr_writedata[15:0];
                c_csr_edge:   w_edge_clr = csr_writedata[WIDTH-1:0];
                default:      ;
            endcase
        end
        // A new edge wins over a same-cycle write-1-to-clear
        edge_d = (edge_q & ~w_edge_clr) | w_edge_set;
    end

    always_comb begin
        w_rdata = '0;
        case (csr_address)
            c_csr_ctrl:   w_rdata[1:0]       = ctrl_q;
            c_csr_period: w_rdata[15:0]      = period_q;
            c_csr_status: w_rdata[WIDTH-1:0] = w_status;
            c_csr_edge:   w_rdata[WIDTH-1:0] = edge_q;
            default:      w_rdata            = '0;
        endcase
        csr_readdata_d = csr_read ? w_rdata : csr_readdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            ctrl_q         <= '0;
            period_q       <= PERIOD_RESET;
            edge_q         <= '0;
            csr_readdata_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            ctrl_q         <= ctrl_d;
            period_q       <= period_d;
            edge_q         <= edge_d;
            csr_readdata_q <= csr_readdata_d;
        end
    end

    assign csr_readdata = csr_readdata_q;
    assign irq          = ctrl_q[c_ctrl_irq_en_bit] & (|edge_q);

endmodule
`default_nettype wire

// File: tb/tb_crypto_wallet_pi_gpio_poller.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_crypto_wallet_pi_gpio_poller : scoreboard bench with behavioural model  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_crypto_wallet_pi_gpio_poller;
    localparam int WIDTH    = 2;
    localparam int DEBOUNCE = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  pio_address;
    logic        pio_read;
    logic [31:0] pio_readdata = 32'd0;
    logic [1:0]  csr_address = 2'd0;
    logic        csr_read = 1'b0;
    logic        csr_write = 1'b0;
    logic [31:0] csr_writedata = 32'd0;
    logic [31:0] csr_readdata;
    logic        irq;

    always #5 clk = ~clk;

    crypto_wallet_pi_gpio_poller #(
        .WIDTH        (WIDTH),
        .PERIOD_RESET (16'd1000),
        .DEBOUNCE     (DEBOUNCE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pio_address   (pio_address),
        .pio_read      (pio_read),
        .pio_readdata  (pio_readdata),
        .csr_address   (csr_address),
        .csr_read      (csr_read),
        .csr_write     (csr_write),
        .csr_writedata (csr_writedata),
        .csr_readdata  (csr_readdata),
        .irq           (irq)
    );

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] v;
    } rd_exp_t;
    rd_exp_t exp_q[$];

    // Behavioural model of the software-visible state
    logic [1:0]       m_ctrl;
    logic [15:0]      m_period;
    logic [WIDTH-1:0] m_stable;
    logic [WIDTH-1:0] m_edge;
    int               m_cnt[WIDTH];

    logic [WIDTH-1:0] in_port = '0;
    logic [WIDTH-1:0] cap_data;
    bit rd_p1, rd_p2, en_p1, en_p2, rd_pending, cont;
    int cyc = 0;
    int last_rd = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ctrl   = '0;
        m_period = 16'd1000;
        m_stable = '0;
        m_edge   = '0;
        for (int b = 0; b < WIDTH; b++) m_cnt[b] = 0;
        rd_p1 = 0; rd_p2 = 0; en_p1 = 0; en_p2 = 0; cont = 0;
    endfunction

    function automatic logic [31:0] model_csr(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_ctrl};
            2'd1:    return {16'd0, m_period};
            2'd2:    return 32'(m_stable);
            default: return 32'(m_edge);
        endcase
    endfunction

    // Monitor/model: runs once per cycle just after the rising edge
    always @(posedge clk) begin
        logic [WIDTH-1:0] new_edge;
        logic [WIDTH-1:0] clr_mask;
        bit en_now;
        int gap;
        #1;
        cyc++;
        if (reset) begin
            model_reset();
            exp_q.delete();
            rd_pending   = 0;
            pio_readdata = $urandom();
        end else begin
            rd_pending = csr_read;
            if (csr_read) exp_q.push_back('{a: csr_address, v: model_csr(csr_address)});

            new_edge = '0;
            if (!en_p1) begin
                for (int b = 0; b < WIDTH; b++) m_cnt[b] = 0;
            end else if (rd_p2 && en_p2) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (cap_data[b] == m_stable[b]) begin
                        m_cnt[b] = 0;
                    end else begin
                        m_cnt[b]++;
                        if (m_cnt[b] >= DEBOUNCE) begin
                            m_stable[b] = cap_data[b];
                            m_cnt[b]    = 0;
                            new_edge[b] = 1'b1;
                        end
                    end
                end
            end

            clr_mask = '0;
            if (csr_write) begin
                case (csr_address)
                    2'd0: m_ctrl   = csr_writedata[1:0];
                    2'd1: m_period = csr_writedata[15:0];
                    2'd3: clr_mask = csr_writedata[WIDTH-1:0];
                    default: ;
                endcase
            end
            m_edge = (m_edge & ~clr_mask) | new_edge;
            en_now = m_ctrl[0];

            check("pio_address", {30'd0, pio_address}, 32'd0);
            if (!en_p1) check("read_while_disabled", {31'd0, pio_read}, 32'd0);
            if (pio_read) begin
                gap = (m_period == 16'd0) ? 3 : int'(m_period) + 2;
                if (cont) check("poll_gap", cyc - last_rd, gap);
                last_rd = cyc;
                cont    = 1;
            end
            if (!en_now) cont = 0;

            check("irq", {31'd0, irq}, {31'd0, m_ctrl[1] & (|m_edge)});

            pio_readdata = $urandom();
            if (rd_p1) begin
                pio_readdata[WIDTH-1:0] = in_port;
                cap_data = in_port;
            end
            rd_p2 = rd_p1;
            rd_p1 = pio_read;
            en_p2 = en_p1;
            en_p1 = en_now;
        end
    end

    // Scoreboard checker: pops on each cycle where a read response is due
    always @(negedge clk) begin
        rd_exp_t e;
        if (!reset && rd_pending) begin
            rd_pending = 0;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL csr_read: response with empty scoreboard, got %h", csr_readdata);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("csr_read[%0d]", e.a), csr_readdata, e.v);
            end
        end
    end

    task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        csr_write = 1'b0;
    endtask

    task automatic csr_rd(input logic [1:0] a);
        @(negedge clk);
        csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_polls(input int k, input int bound);
        for (int i = 0; i < k; i++) begin
            int t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!pio_read && t < bound);
            total++;
            if (!pio_read) begin
                bad++;
                $display("FAIL poll_timeout: got no pio_read in %0d cycles, expected one", bound);
                return;
            end
        end
    endtask

    initial begin
        logic [1:0] drv_ctrl;
        model_reset();
        idle(3);
        reset = 1'b0;

        for (int a = 0; a < 4; a++) csr_rd(2'(a));
        idle(20);

        csr_wr(2'd1, 32'd4);
        csr_wr(2'd0, 32'd1);
        idle(40);
        csr_wr(2'd0, 32'd0);

        csr_wr(2'd1, 32'd2);
        in_port = 2'b00;
        csr_wr(2'd0, 32'd1);
        wait_polls(3, 200);
        in_port = 2'b01;
        wait_polls(4, 200);
        csr_rd(2'd2);
        csr_rd(2'd3);
        in_port = 2'b00;
        wait_polls(1, 200);
        in_port = 2'b01;
        wait_polls(3, 200);
        csr_rd(2'd2);

        csr_wr(2'd0, 32'd3);
        csr_wr(2'd3, 32'd3);
        in_port = 2'b11;
        wait_polls(4, 200);
        csr_rd(2'd3);
        csr_wr(2'd3, 32'd2);
        idle(2);
        wait_polls(1, 200);
        in_port = 2'b01;
        wait_polls(2, 200);
        csr_wr(2'd3, 32'd2);
        csr_rd(2'd3);

        wait_polls(1, 200);
        idle(2);
        in_port = 2'b10;
        csr_wr(2'd0, 32'd0);
        idle(3);
        csr_rd(2'd2);
        csr_wr(2'd0, 32'd1);
        wait_polls(2, 200);
        csr_rd(2'd2);
        wait_polls(2, 200);
        csr_rd(2'd2);
        csr_rd(2'd3);

        csr_wr(2'd0, 32'd0);
        csr_wr(2'd1, 32'd0);
        drv_ctrl = 2'b01;
        csr_wr(2'd0, 32'd1);
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    in_port = WIDTH'($urandom());
                    idle(1);
                end
                4: csr_rd(2'($urandom_range(0, 3)));
                5: csr_wr(2'd3, 32'($urandom_range(0, 3)));
                6: begin
                    drv_ctrl = {1'($urandom()), 1'($urandom_range(0, 3) != 0)};
                    csr_wr(2'd0, {30'd0, drv_ctrl});
                end
                7: begin
                    if (!drv_ctrl[0]) csr_wr(2'd1, 32'($urandom_range(0, 3)));
                    else idle(1);
                end
                default: idle($urandom_range(1, 6));
            endcase
        end

        csr_wr(2'd0, 32'd0);
        csr_wr(2'd1, 32'd2);
        in_port = 2'b00;
        csr_wr(2'd0, 32'd3);
        wait_polls(4, 200);
        in_port = 2'b11;
        wait_polls(4, 200);
        idle(2);
        csr_rd(2'd3);
        wait_polls(1, 200);
        idle(2);
        reset = 1'b1;
        #1;
        check("reset_pio_read", {31'd0, pio_read}, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        check("reset_readdata", csr_readdata, 32'd0);
        idle(3);
        reset = 1'b0;
        idle(20);
        for (int a = 0; a < 4; a++) csr_rd(2'(a));
        csr_wr(2'd0, 32'd1);
        wait_polls(1, 1500);
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
